// File: rtl/cpu_mem.sv
// MEM pipeline stage: passes EX results through, runs load/store transactions on a
// request/acknowledge data bus, formats load data and stalls upstream until done.
package cpu_mem_pkg;
    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_ORI,
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
        OP_SB, OP_SH, OP_SW
    } Oper_t;
endpackage

module cpu_mem
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  Oper_t       op,
    input  logic [31:0] ex_ret,
    input  logic [31:0] store_data,
    output logic [31:0] result,
    output logic        stall_req,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state_q;
    logic          dbus_req_q;
    logic          dbus_we_q;
    logic [3:0]    dbus_be_q;
    logic [31:0]   dbus_addr_q;
    logic [31:0]   dbus_wdata_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   rdata_q;
    Oper_t         op_q;
    logic [1:0]    lo_q;
    logic          abort_q;

    logic        is_load;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic        mem_valid;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_fmt;

    assign is_load    = op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    assign is_store   = op inside {OP_SB, OP_SH, OP_SW};
    assign is_half    = op inside {OP_LH, OP_LHU, OP_SH};
    assign is_word    = op inside {OP_LW, OP_SW};
    assign misaligned = (is_half && ex_ret[0]) || (is_word && (ex_ret[1:0] != 2'b00));
    assign mem_valid  = valid_in && (is_load || is_store);
    assign cnt_d      = cnt_q + 1'b1;

    // Store lane steering: replicate data across lanes, enable only the addressed ones.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = 32'h0;
        case (op)
            OP_SB: begin
                be_d    = 4'b0001 << ex_ret[1:0];
                wdata_d = {4{store_data[7:0]}};
            end
            OP_SH: begin
                be_d    = ex_ret[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{store_data[15:0]}};
            end
            OP_SW:   wdata_d = store_data;
            default: wdata_d = 32'h0;
        endcase
    end

    assign byte_v = 8'(rdata_q >> {lo_q, 3'b000});
    assign half_v = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        load_fmt = rdata_q;
        case (op_q)
            OP_LB:   load_fmt = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  load_fmt = {24'h0, byte_v};
            OP_LH:   load_fmt = {{16{half_v[15]}}, half_v};
            OP_LHU:  load_fmt = {16'h0, half_v};
            OP_LW:   load_fmt = rdata_q;
            default: load_fmt = 32'h0;
        endcase
    end

    always_comb begin
        result    = 32'h0;
        stall_req = 1'b0;
        addr_err  = 1'b0;
        bus_err   = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    if (!mem_valid)      result    = ex_ret;
                    else if (misaligned) addr_err  = 1'b1;
                    else                 stall_req = 1'b1;
                end
                S_BUSY: stall_req = 1'b1;
                S_DONE: begin
                    bus_err = abort_q;
                    result  = abort_q ? 32'h0 : load_fmt;
                end
                default: result = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_be_q    <= 4'h0;
            dbus_addr_q  <= 32'h0;
            dbus_wdata_q <= 32'h0;
            cnt_q        <= '0;
            rdata_q      <= 32'h0;
            op_q         <= OP_NOP;
            lo_q         <= 2'b00;
            abort_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_valid && !misaligned) begin
                        state_q      <= S_BUSY;
                        dbus_req_q   <= 1'b1;
                        dbus_we_q    <= is_store;
                        dbus_be_q    <= be_d;
                        dbus_addr_q  <= {ex_ret[31:2], 2'b00};
                        dbus_wdata_q <= wdata_d;
                        op_q         <= op;
                        lo_q         <= ex_ret[1:0];
                        cnt_q        <= '0;
                        abort_q      <= 1'b0;
                    end
                end
                S_BUSY: begin
                    // An ack on the final counted cycle still wins over the timeout.
                    if (dbus_ack) begin
                        rdata_q    <= dbus_rdata;
                        dbus_req_q <= 1'b0;
                        state_q    <= S_DONE;
                    end else if (cnt_d == CW'(TIMEOUT)) begin
                        dbus_req_q <= 1'b0;
                        abort_q    <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_be    = dbus_be_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_wdata = dbus_wdata_q;

endmodule

// File: tb/tb_cpu_mem.sv
// Bench for cpu_mem: directed vector table, hand-written reset/timeout sequences and
// randomized transactions checked against an arithmetic reference model.
module tb_cpu_mem;
    import cpu_mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    Oper_t       op;
    logic [31:0] ex_ret;
    logic [31:0] store_data;
    logic [31:0] result;
    logic        stall_req;
    logic        addr_err;
    logic        bus_err;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;

    int checks = 0;
    int errors = 0;

    cpu_mem #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .op(op), .ex_ret(ex_ret),
        .store_data(store_data), .result(result), .stall_req(stall_req),
        .addr_err(addr_err), .bus_err(bus_err), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_be(dbus_be), .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        Oper_t       op;
        logic [31:0] addr;
        logic [31:0] sd;
        int          waits;
        logic [31:0] rd;
        logic [31:0] res;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          aerr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_is_store(input Oper_t o);
        return (o == OP_SB) || (o == OP_SH) || (o == OP_SW);
    endfunction

    function automatic bit m_is_mem(input Oper_t o);
        return m_is_store(o) || (o == OP_LB) || (o == OP_LBU) || (o == OP_LH) ||
               (o == OP_LHU) || (o == OP_LW);
    endfunction

    function automatic int m_size(input Oper_t o);
        if (o == OP_LB || o == OP_LBU || o == OP_SB) return 1;
        if (o == OP_LH || o == OP_LHU || o == OP_SH) return 2;
        return 4;
    endfunction

    function automatic bit m_misaligned(input Oper_t o, input logic [31:0] a);
        return (a % m_size(o)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input Oper_t o, input logic [31:0] a);
        if (o == OP_SB) return 4'(1 << (a % 4));
        if (o == OP_SH) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input Oper_t o, input logic [31:0] sd);
        if (o == OP_SB) return (sd & 32'hFF) * 32'h0101_0101;
        if (o == OP_SH) return (sd & 32'hFFFF) * 32'h0001_0001;
        if (o == OP_SW) return sd;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_load(input Oper_t o, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        if (o == OP_LW) return rd;
        if (o == OP_LB || o == OP_LBU) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (o == OP_LB && v >= 32'd128) v = v - 32'd256;
            return v;
        end
        if (o == OP_LH || o == OP_LHU) begin
            v = (rd >> (8 * (a & 2))) & 32'hFFFF;
            if (o == OP_LH && v >= 32'd32768) v = v - 32'd65536;
            return v;
        end
        return 32'h0;
    endfunction

    // One complete memory transaction: issue, waits, DONE, and a follow-up idle cycle.
    task automatic do_txn(input Oper_t o, input logic [31:0] a, input logic [31:0] sd,
                          input int waits, input bit no_ack, input logic [31:0] rd,
                          input logic [31:0] exp_res, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input bit exp_aerr, input bit exp_berr);
        int n;
        logic [31:0] seen;
        tick();
        valid_in = 1'b1; op = o; ex_ret = a; store_data = sd;
        dbus_ack = 1'b0; dbus_rdata = rd;
        @(negedge clk);
        if (exp_aerr) begin
            chk("aerr_flag", addr_err, 1);
            chk("aerr_result", result, 0);
            chk("aerr_stall", stall_req, 0);
            tick();
            valid_in = 1'b0; op = OP_NOP;
            @(negedge clk);
            chk("aerr_noreq", dbus_req, 0);
            chk("aerr_once", addr_err, 0);
            $display("txn op=%s addr=%08h misaligned", o.name(), a);
            return;
        end
        chk("issue_stall", stall_req, 1);
        chk("issue_noreq", dbus_req, 0);
        chk("issue_aerr", addr_err, 0);
        n = no_ack ? TO : waits + 1;
        for (int k = 0; k < n; k++) begin
            tick();
            dbus_ack = !no_ack && (k == waits);
            @(negedge clk);
            chk("busy_req", dbus_req, 1);
            chk("busy_we", dbus_we, m_is_store(o));
            chk("busy_be", dbus_be, exp_be);
            chk("busy_addr", dbus_addr, a & 32'hFFFF_FFFC);
            chk("busy_wdata", dbus_wdata, exp_wd);
            chk("busy_stall", stall_req, 1);
        end
        tick();
        dbus_ack = 1'b0;
        @(negedge clk);
        seen = result;
        chk("done_stall", stall_req, 0);
        chk("done_result", result, exp_res);
        chk("done_berr", bus_err, exp_berr);
        chk("done_req", dbus_req, 0);
        tick();
        valid_in = 1'b0; op = OP_NOP;
        @(negedge clk);
        chk("after_req", dbus_req, 0);
        chk("after_stall", stall_req, 0);
        chk("after_berr", bus_err, 0);
        $display("txn op=%s addr=%08h result=%08h berr=%0d", o.name(), a, seen, exp_berr);
    endtask

    initial begin
        Oper_t       r_op;
        logic [31:0] r_a, r_sd, r_rd;
        int          r_w;
        bit          r_na, r_v;

        vecs[0]  = '{OP_LB,  32'h0000_1003, 32'h0,          0, 32'h80AA_BBCC, 32'hFFFF_FF80, 4'hF, 32'h0,          1'b0};
        vecs[1]  = '{OP_LBU, 32'h0000_1003, 32'h0,          0, 32'h80AA_BBCC, 32'h0000_0080, 4'hF, 32'h0,          1'b0};
        vecs[2]  = '{OP_SH,  32'h0000_2002, 32'hDEAD_BEEF,  2, 32'h1111_1111, 32'h0,         4'hC, 32'hBEEF_BEEF,  1'b0};
        vecs[3]  = '{OP_LW,  32'h0000_0006, 32'h0,          0, 32'h0,         32'h0,         4'hF, 32'h0,          1'b1};
        vecs[4]  = '{OP_LH,  32'h0000_1002, 32'h0,          1, 32'h8001_1234, 32'hFFFF_8001, 4'hF, 32'h0,          1'b0};
        vecs[5]  = '{OP_LHU, 32'h0000_1000, 32'h0,          0, 32'h8001_9234, 32'h0000_9234, 4'hF, 32'h0,          1'b0};
        vecs[6]  = '{OP_LW,  32'h0000_1004, 32'h0,          3, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'hF, 32'h0,          1'b0};
        vecs[7]  = '{OP_SB,  32'h0000_0011, 32'h1234_5699,  1, 32'h0,         32'h0,         4'h2, 32'h9999_9999,  1'b0};
        vecs[8]  = '{OP_SW,  32'h0000_3000, 32'hA5A5_0F0F,  0, 32'h0,         32'h0,         4'hF, 32'hA5A5_0F0F,  1'b0};
        vecs[9]  = '{OP_LH,  32'h0000_0001, 32'h0,          0, 32'h0,         32'h0,         4'hF, 32'h0,          1'b1};
        vecs[10] = '{OP_SH,  32'h0000_0003, 32'h0,          0, 32'h0,         32'h0,         4'hF, 32'h0,          1'b1};
        vecs[11] = '{OP_SB,  32'h0000_0003, 32'h0000_00AB,  0, 32'h0,         32'h0,         4'h8, 32'hABAB_ABAB,  1'b0};
        vecs[12] = '{OP_LB,  32'h0000_1001, 32'h0,          2, 32'h0000_7F00, 32'h0000_007F, 4'hF, 32'h0,          1'b0};

        // Reset with a live instruction present: all flags must stay low.
        rst = 1'b1; valid_in = 1'b1; op = OP_ORI; ex_ret = 32'h9999_0000;
        store_data = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_aerr", addr_err, 0);
        chk("rst_berr", bus_err, 0);
        chk("rst_req", dbus_req, 0);
        chk("rst_we", dbus_we, 0);
        chk("rst_be", dbus_be, 0);
        chk("rst_addr", dbus_addr, 0);
        chk("rst_wdata", dbus_wdata, 0);

        // Non-memory passthrough.
        tick();
        rst = 1'b0; valid_in = 1'b1; op = OP_ORI; ex_ret = 32'h1234_5678;
        @(negedge clk);
        chk("ori_result", result, 32'h1234_5678);
        chk("ori_stall", stall_req, 0);
        tick();
        valid_in = 1'b0; op = OP_NOP;
        @(negedge clk);
        chk("ori_noreq", dbus_req, 0);
        $display("txn op=OP_ORI addr=12345678 passthrough");

        for (int i = 0; i < 13; i++)
            do_txn(vecs[i].op, vecs[i].addr, vecs[i].sd, vecs[i].waits, 1'b0, vecs[i].rd,
                   vecs[i].res, vecs[i].be, vecs[i].wd, vecs[i].aerr, 1'b0);

        // Timeout abort, then a late ack that must be ignored.
        do_txn(OP_LW, 32'h0000_4000, 32'h0, 0, 1'b1, 32'h5A5A_5A5A, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
        tick();
        dbus_ack = 1'b1; ex_ret = 32'h0000_5555;
        @(negedge clk);
        chk("late_ack_result", result, 32'h0000_5555);
        chk("late_ack_stall", stall_req, 0);
        chk("late_ack_req", dbus_req, 0);
        tick();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_berr", bus_err, 0);
        chk("late_ack_idle", stall_req, 0);

        // Reset during BUSY discards the pending load.
        tick();
        valid_in = 1'b1; op = OP_LHU; ex_ret = 32'h0000_1000;
        @(negedge clk);
        chk("rb_issue_stall", stall_req, 1);
        tick();
        @(negedge clk);
        chk("rb_busy_req", dbus_req, 1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rb_rst_result", result, 0);
        chk("rb_rst_stall", stall_req, 0);
        tick();
        @(negedge clk);
        chk("rb_req_dropped", dbus_req, 0);
        tick();
        rst = 1'b0; valid_in = 1'b0; op = OP_NOP; dbus_ack = 1'b1;
        @(negedge clk);
        chk("rb_idle_result", result, 32'h0000_1000);
        chk("rb_idle_stall", stall_req, 0);
        tick();
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("rb_idle_req", dbus_req, 0);
        chk("rb_idle_noerr", bus_err, 0);
        $display("txn op=OP_LHU addr=00001000 reset-aborted");
        do_txn(OP_SW, 32'h0000_3000, 32'h0BAD_F00D, 1, 1'b0, 32'h0, 32'h0, 4'hF,
               32'h0BAD_F00D, 1'b0, 1'b0);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 150; i++) begin
            r_op = Oper_t'($urandom_range(0, 10));
            r_a  = $urandom();
            r_sd = $urandom();
            r_rd = $urandom();
            r_w  = $urandom_range(0, TO - 1);
            r_na = ($urandom_range(0, 7) == 0);
            r_v  = ($urandom_range(0, 5) != 0);
            if (!r_v || !m_is_mem(r_op)) begin
                tick();
                valid_in = r_v; op = r_op; ex_ret = r_a; dbus_ack = 1'b0;
                @(negedge clk);
                chk("rnd_pass_result", result, r_a);
                chk("rnd_pass_stall", stall_req, 0);
                chk("rnd_pass_aerr", addr_err, 0);
                $display("txn op=%s addr=%08h valid=%0d passthrough", r_op.name(), r_a, r_v);
            end else begin
                do_txn(r_op, r_a, r_sd, r_w, r_na, r_rd,
                       r_na ? 32'h0 : m_load(r_op, r_a, r_rd),
                       m_be(r_op, r_a), m_wdata(r_op, r_sd),
                       m_misaligned(r_op, r_a), r_na);
            end
        end
        tick();
        valid_in = 1'b0; op = OP_NOP;
        @(negedge clk);
        chk("final_idle_req", dbus_req, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
